reu_dram_ctrl: RTL



---
 rtl/reu_dram_ctrl.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/reu_dram_ctrl.sv
// rtl/reu_dram_ctrl.sv - DRAM sequencer behind the REU core: byte read/write access plus CBR refresh
//
// Ports:
//   DotClk  in   sole clock, rising edge
//   RESET   in   synchronous, active-high reset
//   Req     in   access request level, held until Ack
//   Wr      in   1 = write, 0 = read (captured with Req)
//   Addr    in   21-bit REU byte address (row = [20:10], col = [9:0])
//   WData   in   write byte (captured with Req)
//   Ack     out  one-cycle completion pulse
//   RData   out  last read byte, updated at the read's Ack
//   Busy    out  high from acceptance / refresh start until back in IDLE
//   RA      out  multiplexed DRAM row/column address
//   nRAS    out  row strobe, active low
//   nCAS    out  column strobe, active low
//   nRWE    out  DRAM write enable, active low
//   RD      io   DRAM data, driven only while a write is in COL..HOLD
module reu_dram_ctrl #(
    parameter int ROW_BITS     = 11,
    parameter int COL_BITS     = 10,
    parameter int REF_INTERVAL = 120,
    parameter int PRE_CYC      = 2
) (
    input  logic                DotClk,
    input  logic                RESET,
    input  logic                Req,
    input  logic                Wr,
    input  logic [20:0]         Addr,
    input  logic [7:0]          WData,
    output logic                Ack,
    output logic [7:0]          RData,
    output logic                Busy,
    output logic [ROW_BITS-1:0] RA,
    output logic                nRAS,
    output logic                nCAS,
    output logic                nRWE,
    inout  wire  [7:0]          RD
);

    localparam int RW = $clog2(REF_INTERVAL);
    localparam int PW = (PRE_CYC > 1) ? $clog2(PRE_CYC) : 1;
    localparam logic [RW-1:0] REF_LOAD = RW'(REF_INTERVAL - 1);
    localparam logic [PW-1:0] PRE_LOAD = PW'(PRE_CYC - 1);

    typedef enum logic [3:0] {
        S_IDLE, S_RAS, S_COL, S_CAS, S_HOLD,
        S_REF1, S_REF2, S_REF3, S_REF4, S_PRE
    } state_t;

    state_t                state, state_d;
    logic [RW-1:0]         ref_cnt, ref_cnt_d;
    logic                  ref_pend, ref_pend_d;
    logic [PW-1:0]         pre_cnt, pre_cnt_d;
    logic                  wr_l, wr_d;
    logic [COL_BITS-1:0]   col_l, col_d;
    logic [7:0]            wdata_l, wdata_d;
    logic [ROW_BITS-1:0]   ra_d;
    logic                  nras_d, ncas_d, nrwe_d;
    logic                  rd_oe, rd_oe_d;
    logic                  ack_d, busy_d;
    logic [7:0]            rdata_d;

    assign RD = rd_oe ? wdata_l : 8'hzz;

    always_comb begin
        state_d    = state;
        ref_pend_d = ref_pend;
        pre_cnt_d  = pre_cnt;
        wr_d       = wr_l;
        col_d      = col_l;
        wdata_d    = wdata_l;
        ra_d       = RA;
        nras_d     = nRAS;
        ncas_d     = nCAS;
        nrwe_d     = nRWE;
        rd_oe_d    = rd_oe;
        ack_d      = 1'b0;
        busy_d     = Busy;
        rdata_d    = RData;
        ref_cnt_d  = (ref_cnt == '0) ? REF_LOAD : ref_cnt - 1'b1;

        case (state)
            S_IDLE: begin
                // Refresh wins a same-cycle collision; the request simply waits.
                if (ref_pend) begin
                    ref_pend_d = 1'b0;
                    busy_d     = 1'b1;
                    state_d    = S_REF1;
                end else if (Req) begin
                    wr_d    = Wr;
                    col_d   = Addr[COL_BITS-1:0];
                    wdata_d = WData;
                    ra_d    = Addr[COL_BITS +: ROW_BITS];
                    busy_d  = 1'b1;
                    state_d = S_RAS;
                end
            end
            S_RAS: begin
                nras_d  = 1'b0;
                state_d = S_COL;
            end
            S_COL: begin
                ra_d    = ROW_BITS'(col_l);
                nrwe_d  = ~wr_l;
                rd_oe_d = wr_l;
                state_d = S_CAS;
            end
            S_CAS: begin
                ncas_d  = 1'b0;
                state_d = S_HOLD;
            end
            S_HOLD: begin
                if (!wr_l) rdata_d = RD;
                ack_d     = 1'b1;
                nras_d    = 1'b1;
                ncas_d    = 1'b1;
                nrwe_d    = 1'b1;
                rd_oe_d   = 1'b0;
                pre_cnt_d = PRE_LOAD;
                state_d   = S_PRE;
            end
            // CAS-before-RAS: nCAS leads nRAS by one cycle, nRWE stays high.
            S_REF1: begin
                ncas_d  = 1'b0;
                busy_d  = 1'b1;
                state_d = S_REF2;
            end
            S_REF2: begin
                nras_d  = 1'b0;
                state_d = S_REF3;
            end
            S_REF3: state_d = S_REF4;
            S_REF4: begin
                nras_d    = 1'b1;
                ncas_d    = 1'b1;
                pre_cnt_d = PRE_LOAD;
                state_d   = S_PRE;
            end
            S_PRE: begin
                if (pre_cnt == '0) begin
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    pre_cnt_d = pre_cnt - 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Timer expiry sets the flag; a second expiry while pending is absorbed.
        if (ref_cnt == '0) ref_pend_d = 1'b1;
    end

    always_ff @(posedge DotClk) begin
        if (RESET) begin
            state    <= S_IDLE;
            ref_cnt  <= REF_LOAD;
            ref_pend <= 1'b0;
            pre_cnt  <= '0;
            wr_l     <= 1'b0;
            col_l    <= '0;
            wdata_l  <= '0;
            RA       <= '0;
            nRAS     <= 1'b1;
            nCAS     <= 1'b1;
            nRWE     <= 1'b1;
            rd_oe    <= 1'b0;
            Ack      <= 1'b0;
            Busy     <= 1'b0;
            RData    <= '0;
        end else begin
            state    <= state_d;
            ref_cnt  <= ref_cnt_d;
            ref_pend <= ref_pend_d;
            pre_cnt  <= pre_cnt_d;
            wr_l     <= wr_d;
            col_l    <= col_d;
            wdata_l  <= wdata_d;
            RA       <= ra_d;
            nRAS     <= nras_d;
            nCAS     <= ncas_d;
            nRWE     <= nrwe_d;
            rd_oe    <= rd_oe_d;
            Ack      <= ack_d;
            Busy     <= busy_d;
            RData    <= rdata_d;
        end
    end

endmodule
